// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and SPI mode helpers for the SPI register port
package spi_reg_pkg;

  typedef enum logic [1:0] {
    CMD_RD   = 2'b00,
    CMD_RSV  = 2'b01,
    CMD_WR   = 2'b10,
    CMD_FAST = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Modes 0 and 3 capture MOSI on the rising sclk edge; modes 1 and 2 on the falling edge.
  function automatic logic samples_on_rise(input logic [1:0] mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - synchroniser and edge detector for the SPI pins
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic sclk,
  input  logic mosi,
  input  logic nss,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic nss_fall,
  output logic nss_rise,
  output logic nss_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, mosi_q, mosi_d, nss_q, nss_d, vld_q, vld_d;
  logic sclk_prev_q, sclk_prev_d, nss_prev_q, nss_prev_d, armed_q, armed_d;

  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi};
    nss_d       = {nss_q[SYNC_STAGES-2:0], nss};
    vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
    nss_prev_d  = nss_q[SYNC_STAGES-1];
    // A frame may only start once a genuinely sampled high nss has been seen after reset.
    armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & nss_q[SYNC_STAGES-1]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_q      <= '0;
      mosi_q      <= '0;
      nss_q       <= '1;
      vld_q       <= '0;
      sclk_prev_q <= 1'b0;
      nss_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      nss_q       <= nss_d;
      vld_q       <= vld_d;
      sclk_prev_q <= sclk_prev_d;
      nss_prev_q  <= nss_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign nss_s     = nss_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_q[SYNC_STAGES-1];
  assign nss_fall  = armed_q & nss_prev_q & ~nss_s;
  assign nss_rise  = ~nss_prev_q & nss_s;

endmodule

// File: rtl/spi_reg_mode.sv
// rtl/spi_reg_mode.sv - SPI slave register-access engine with runtime CPOL/CPHA and burst access
module spi_reg_mode
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int REG_W       = 8,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        spi_mode,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              nss,
  output logic              miso,
  output logic              miso_oe,
  input  logic [7:0]        status,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic              reg_rd_stb,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_wr_vld,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(REG_W) + 1;

  logic sclk_rise, sclk_fall, nss_fall, nss_rise, nss_s, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (clk),
    .nrst     (nrst),
    .sclk     (sclk),
    .mosi     (mosi),
    .nss      (nss),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .nss_fall (nss_fall),
    .nss_rise (nss_rise),
    .nss_s    (nss_s),
    .mosi_s   (mosi_s)
  );

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [1:0]         mode_q, mode_d;
  logic [REG_W-1:0]   osr_q, osr_d, data_o_q, data_o_d;
  logic [REG_W-2:0]   isr_q, isr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [5:0]         fast_q, fast_d;
  logic               skip_q, skip_d, rd_stb_q, rd_stb_d, wr_vld_q, wr_vld_d;
  logic               fast_vld_q, fast_vld_d, err_q, err_d;

  logic               sample_edge, shift_edge, addr_bad;
  logic [REG_W-1:0]   isr_shift;
  logic [7:0]         cmd_byte;
  logic [ADDR_W-1:0]  addr_inc;

  assign sample_edge = samples_on_rise(mode_q) ? sclk_rise : sclk_fall;
  assign shift_edge  = samples_on_rise(mode_q) ? sclk_fall : sclk_rise;
  assign isr_shift   = {isr_q, mosi_s};
  assign cmd_byte    = isr_shift[7:0];
  assign addr_bad    = {1'b0, cmd_byte[ADDR_W-1:0]} >= (ADDR_W+1)'(NUM_REGS);
  assign addr_inc    = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mode_d     = mode_q;
    osr_d      = osr_q;
    isr_d      = isr_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    addr_d     = addr_q;
    data_o_d   = data_o_q;
    fast_d     = fast_q;
    rd_stb_d   = 1'b0;
    wr_vld_d   = 1'b0;
    fast_vld_d = 1'b0;
    err_d      = 1'b0;
    // Burst address advances the cycle after each data strobe.
    if (rd_stb_q || wr_vld_q) addr_d = addr_inc;
    case (state_q)
      IDLE: begin
        if (nss_fall) begin
          state_d = CMD;
          mode_d  = spi_mode;
          osr_d   = '0;
          osr_d[REG_W-1 -: 8] = status;
          cnt_d   = '0;
          skip_d  = spi_mode[0];
        end
      end
      CMD, DATA: begin
        if (nss_rise) begin
          err_d   = (cnt_q != '0);
          osr_d   = '0;
          state_d = IDLE;
        end else begin
          if (shift_edge) begin
            // With CPHA=1 the MSB is already on miso, so the leading shift edge is swallowed.
            if (skip_q) skip_d = 1'b0;
            else if (state_q == DATA && cmd_q == CMD_RD && cnt_q == '0) begin
              osr_d    = reg_data_i;
              rd_stb_d = 1'b1;
            end else osr_d = {osr_q[REG_W-2:0], 1'b0};
          end
          if (sample_edge) begin
            isr_d = isr_shift[REG_W-2:0];
            if (state_q == CMD) begin
              if (cnt_q == CW'(7)) begin
                cnt_d = '0;
                cmd_d = cmd_e'(cmd_byte[7:6]);
                case (cmd_e'(cmd_byte[7:6]))
                  CMD_FAST: begin
                    fast_d     = cmd_byte[5:0];
                    fast_vld_d = 1'b1;
                    state_d    = WAIT;
                  end
                  CMD_RSV: begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                  end
                  default: begin
                    if (addr_bad) begin
                      err_d   = 1'b1;
                      state_d = WAIT;
                    end else begin
                      addr_d  = cmd_byte[ADDR_W-1:0];
                      state_d = DATA;
                    end
                  end
                endcase
              end else cnt_d = cnt_q + 1'b1;
            end else if (cnt_q == CW'(REG_W - 1)) begin
              cnt_d = '0;
              if (cmd_q == CMD_WR) begin
                data_o_d = isr_shift;
                wr_vld_d = 1'b1;
              end
            end else cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (nss_rise) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_RD;
      mode_q     <= MODE0;
      osr_q      <= '0;
      isr_q      <= '0;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      addr_q     <= '0;
      data_o_q   <= '0;
      fast_q     <= '0;
      rd_stb_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      fast_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      osr_q      <= osr_d;
      isr_q      <= isr_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      addr_q     <= addr_d;
      data_o_q   <= data_o_d;
      fast_q     <= fast_d;
      rd_stb_q   <= rd_stb_d;
      wr_vld_q   <= wr_vld_d;
      fast_vld_q <= fast_vld_d;
      err_q      <= err_d;
    end
  end

  assign miso        = osr_q[REG_W-1];
  assign miso_oe     = ~nss_s;
  assign reg_addr    = addr_q;
  assign reg_data_o  = data_o_q;
  assign reg_rd_stb  = rd_stb_q;
  assign reg_wr_vld  = wr_vld_q;
  assign fastcmd     = fast_q;
  assign fastcmd_vld = fast_vld_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule
